updown_count_monitor: RTL
=========================

// Module: updown_count_monitor
// PURPOSE
//   Passive observer for the 4-bit up/down counter output. Samples the count bus and
//   classifies each step: up, down, hold or illegal. Derives the current count direction,
//   flags wrap-around events, and keeps saturating wrap and error statistics.
//   Sits beside the counter in the design and in benches, and gives a self-checking
//   reader for the counter's value stream.
// PARAMETERS
//   WIDTH       4   width of observed count bus
//   ERR_CNT_W   8   width of saturating illegal-step counter
//   WRAP_CNT_W  8   width of saturating wrap-event counter
// PORTS
//   clock       in   1           rising-edge clock, shared with the counter
//   rst         in   1           asynchronous, active-high reset
//   sample_en   in   1           count_in is valid this cycle
//   clear       in   1           synchronous clear of FSM and statistics
//   count_in    in   WIDTH       observed counter value
//   dir_valid   out  1           direction known (FSM in S_UP or S_DOWN)
//   dir_up      out  1           1=counting up, 0=down; meaningful only when dir_valid=1
//   hold        out  1           1-cycle pulse: sampled value equal to previous
//   dir_change  out  1           1-cycle pulse: legal step reversed direction
//   wrap_up     out  1           1-cycle pulse: max->0 up step
//   wrap_dn     out  1           1-cycle pulse: 0->max down step
//   step_err    out  1           1-cycle pulse: illegal step
//   wrap_count  out  WRAP_CNT_W  saturating count of wrap_up + wrap_dn events
//   err_count   out  ERR_CNT_W   saturating count of step_err events
// BEHAVIOUR
//   - rst=1, asynchronous: all outputs 0, prev=0, FSM=S_EMPTY, effective immediately;
//     may be asserted mid-stream.
//   - All outputs registered. Latency is 1 cycle: a sample accepted at edge N is reflected
//     after edge N+1. Pulses last exactly 1 cycle and are 0 when sample_en=0.
//   - Step class: diff = (count_in - prev) mod 2^WIDTH.
//     UP if diff==1; DOWN if diff=={WIDTH{1'b1}}; HOLD if diff==0; else ERR.
//   - FSM states: S_EMPTY -> S_PRIMED -> S_UP / S_DOWN.
//     - S_EMPTY: first sample -> store prev, go to S_PRIMED. No pulses.
//     - S_PRIMED: UP->S_UP; DOWN->S_DOWN; HOLD->stay, hold pulse; ERR->stay, step_err.
//     - S_UP: UP->stay; DOWN->S_DOWN + dir_change; HOLD->stay + hold; ERR->S_PRIMED + step_err.
//     - S_DOWN: mirror of S_UP.
//   - prev updates on every accepted sample, including ERR. After an error, direction
//     is re-acquired from the bad value.
//   - Wrap detection:
//     - wrap_up when UP and prev=={WIDTH{1'b1}}.
//     - wrap_dn when DOWN and prev==0.
//     - A wrap also raises dir_change if it reverses direction.
//   - Counters saturate at all-ones and never roll over.
//   - clear=1: FSM->S_EMPTY, both counters->0, pulses->0, dir_valid->0.
//     If sample_en=1 in the same cycle, clear wins and the sample is discarded.
//   - count_in is ignored when sample_en=0. X on count_in while sample_en=0 is legal.
// STRUCTURE
//   - Package updown_mon_pkg:
//     - state encodings S_EMPTY=2'd0, S_PRIMED=2'd1, S_UP=2'd2, S_DOWN=2'd3
//     - step codes STEP_HOLD, STEP_UP, STEP_DN, STEP_ERR (2 bits)
//   - Sub-module updown_step_classify (combinational):
//     inputs prev, count_in; outputs step code, is_max_prev, is_zero_prev.
//   - Top holds the prev register, FSM, pulse registers and two saturating counters.
// TESTING (WIDTH=4, one sample per cycle)
//   1. rst, then 3,4,5 -> S_UP after 3rd sample; dir_valid=1, dir_up=1, err_count=0.
//   2. 14,15,0,1 -> wrap_up pulses once, 1 cycle after the 0 sample; wrap_count=1; dir_up=1.
//   3. 5,6,5 -> dir_change pulse on the 5, dir_up=0. Then 5 -> hold pulse, state unchanged.
//   4. 1,0,15,9,10 -> wrap_dn once.
//      On 9: step_err, err_count=1, dir_valid=0. On 10: dir_up=1.
//   5. 300 illegal steps (alternate 0,8) -> err_count=255 and stays.
//      Then clear -> err_count=0, FSM S_EMPTY.
//   6. rst mid-stream -> outputs 0 within same cycle.
//      clear+sample_en together -> sample dropped, next sample only primes.

Source files
------------

// File: rtl/updown_mon_pkg.sv
// Shared encodings for the up/down counter monitor.
// FSM state constants and step classification codes.
package updown_mon_pkg;

    localparam logic [1:0] S_EMPTY  = 2'd0;
    localparam logic [1:0] S_PRIMED = 2'd1;
    localparam logic [1:0] S_UP     = 2'd2;
    localparam logic [1:0] S_DOWN   = 2'd3;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2,
        STEP_ERR  = 2'd3
    } step_e;

endpackage

// File: rtl/updown_count_monitor_if.sv
// Observation bus between a counter sampler and the monitor.
// master drives samples, slave (the monitor) returns status.
interface updown_count_monitor_if
    import updown_mon_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 8
);

    logic                  sample_en;
    logic                  clear;
    logic [WIDTH-1:0]      count_in;
    logic                  dir_valid;
    logic                  dir_up;
    logic                  hold;
    logic                  dir_change;
    logic                  wrap_up;
    logic                  wrap_dn;
    logic                  step_err;
    logic [WRAP_CNT_W-1:0] wrap_count;
    logic [ERR_CNT_W-1:0]  err_count;

    modport master (
        output sample_en, clear, count_in,
        input  dir_valid, dir_up, hold, dir_change,
        input  wrap_up, wrap_dn, step_err,
        input  wrap_count, err_count
    );

    modport slave (
        input  sample_en, clear, count_in,
        output dir_valid, dir_up, hold, dir_change,
        output wrap_up, wrap_dn, step_err,
        output wrap_count, err_count
    );

endinterface

// File: rtl/updown_step_classify.sv
// Classifies one counter step from the previous to the new value.
// Pure combinational; wrap decisions use the prev flags.
module updown_step_classify
    import updown_mon_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] count_in,
    output step_e            step,
    output logic             is_max_prev,
    output logic             is_zero_prev
);

    logic [WIDTH-1:0] diff;

    assign diff         = count_in - prev;
    assign is_max_prev  = (prev == {WIDTH{1'b1}});
    assign is_zero_prev = (prev == '0);

    // modular difference of +1 / -1 / 0 is a legal step
    always_comb begin
        step = STEP_ERR;
        unique case (1'b1)
            (diff == WIDTH'(1)):       step = STEP_UP;
            (diff == {WIDTH{1'b1}}):   step = STEP_DN;
            (diff == '0):              step = STEP_HOLD;
            default:                   step = STEP_ERR;
        endcase
    end

endmodule

// File: rtl/updown_count_monitor.sv
// Passive monitor for an up/down counter value stream.
// Tracks direction, wraps and illegal steps with saturating stats.
module updown_count_monitor
    import updown_mon_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                   clock,
    input  logic                   rst,
    updown_count_monitor_if.slave  mon
);

    logic [WIDTH-1:0]      prev;
    logic [1:0]            state;
    logic [1:0]            state_nxt;
    step_e                 step;
    logic                  is_max_prev;
    logic                  is_zero_prev;
    logic                  accept;

    logic                  hold_n, dchg_n, wup_n, wdn_n, err_n;
    logic                  hold_q, dchg_q, wup_q, wdn_q, err_q;
    logic [WRAP_CNT_W-1:0] wrap_cnt;
    logic [ERR_CNT_W-1:0]  err_cnt;

    updown_step_classify #(
        .WIDTH (WIDTH)
    ) u_classify (
        .prev         (prev),
        .count_in     (mon.count_in),
        .step         (step),
        .is_max_prev  (is_max_prev),
        .is_zero_prev (is_zero_prev)
    );

    assign accept = mon.sample_en & ~mon.clear;

    // next state and pulse decode for an accepted sample
    always_comb begin
        state_nxt = state;
        hold_n    = 1'b0;
        dchg_n    = 1'b0;
        wup_n     = 1'b0;
        wdn_n     = 1'b0;
        err_n     = 1'b0;
        if (accept) begin
            if (state == S_EMPTY) begin
                state_nxt = S_PRIMED;
            end else begin
                unique case (step)
                    STEP_HOLD: hold_n = 1'b1;
                    STEP_UP: begin
                        state_nxt = S_UP;
                        wup_n     = is_max_prev;
                        dchg_n    = (state == S_DOWN);
                    end
                    STEP_DN: begin
                        state_nxt = S_DOWN;
                        wdn_n     = is_zero_prev;
                        dchg_n    = (state == S_UP);
                    end
                    default: begin
                        state_nxt = S_PRIMED;
                        err_n     = 1'b1;
                    end
                endcase
            end
        end
    end

    // FSM and previous-value register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= S_EMPTY;
            prev  <= '0;
        end else if (mon.clear) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
            if (accept) prev <= mon.count_in;
        end
    end

    // single-cycle event pulses
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            hold_q <= 1'b0;
            dchg_q <= 1'b0;
            wup_q  <= 1'b0;
            wdn_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            hold_q <= hold_n;
            dchg_q <= dchg_n;
            wup_q  <= wup_n;
            wdn_q  <= wdn_n;
            err_q  <= err_n;
        end
    end

    // saturating wrap and error statistics
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wrap_cnt <= '0;
            err_cnt  <= '0;
        end else if (mon.clear) begin
            wrap_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if ((wup_n | wdn_n) && (wrap_cnt != {WRAP_CNT_W{1'b1}}))
                wrap_cnt <= wrap_cnt + WRAP_CNT_W'(1);
            if (err_n && (err_cnt != {ERR_CNT_W{1'b1}}))
                err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

    assign mon.dir_valid  = (state == S_UP) || (state == S_DOWN);
    assign mon.dir_up     = (state == S_UP);
    assign mon.hold       = hold_q;
    assign mon.dir_change = dchg_q;
    assign mon.wrap_up    = wup_q;
    assign mon.wrap_dn    = wdn_q;
    assign mon.step_err   = err_q;
    assign mon.wrap_count = wrap_cnt;
    assign mon.err_count  = err_cnt;

endmodule
